// File: rtl/lfsr_pkg.sv
// Shared definitions for the 32-bit LFSR random source and its receive-side checker.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 32;
  localparam logic [LFSR_W-1:0] LFSR_TAP_MASK = 32'hEA000001;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } chk_state_t;

  // One generator step: feedback is the parity of the tapped bits, shifted in at the MSB.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] x);
    return {^(x & LFSR_TAP_MASK), x[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 32-bit LFSR word stream: hunts, verifies, then flywheels.
// Optional words-checked counter is built only when LFSR_CHK_WORDCNT_EN is defined.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_THRESH = 4,
  parameter int unsigned LOSS_THRESH = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] data_i,
  input  logic              data_v,
  input  logic              seed_v,
  input  logic              clr_i,
  output logic              locked_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [CNT_W-1:0]  words_cnt_o
);

  localparam logic [3:0] LockThr = 4'(LOCK_THRESH);
  localparam logic [3:0] LossThr = 4'(LOSS_THRESH);

  chk_state_t        state_q;
  logic [LFSR_W-1:0] pred_q;
  logic [3:0]        run_q;
  logic [3:0]        miss_q;
  logic              locked_q;
  logic              err_q;

  logic match;
  logic step_en;
  logic err_inc;

  assign match   = (data_i == pred_q);
  // seed_v discards any word presented in the same cycle.
  assign step_en = data_v & ~seed_v;
  assign err_inc = step_en & (state_q == LOCKED) & ~match;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= HUNT;
      pred_q   <= '0;
      run_q    <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (seed_v) begin
        state_q  <= HUNT;
        run_q    <= '0;
        miss_q   <= '0;
        locked_q <= 1'b0;
      end else if (data_v) begin
        unique case (state_q)
          HUNT: begin
            // Zero is the lock-up word and can never come from a running generator.
            if (data_i != '0) begin
              pred_q  <= lfsr_step(data_i);
              run_q   <= '0;
              state_q <= VERIFY;
            end
          end
          VERIFY: begin
            pred_q <= lfsr_step(data_i);
            if (match) begin
              run_q <= run_q + 4'd1;
              if ((run_q + 4'd1) == LockThr) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              run_q <= '0;
            end
          end
          LOCKED: begin
            // Flywheel: once locked the stream never reseeds the predictor.
            pred_q <= lfsr_step(pred_q);
            if (match) begin
              miss_q <= '0;
            end else begin
              err_q <= 1'b1;
              if ((miss_q + 4'd1) == LossThr) begin
                state_q  <= HUNT;
                locked_q <= 1'b0;
                miss_q   <= '0;
              end else begin
                miss_q <= miss_q + 4'd1;
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign locked_o = locked_q;
  assign err_o    = err_q;

  sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(err_inc),
    .clr_i(clr_i),
    .cnt_o(err_cnt_o)
  );

`ifdef LFSR_CHK_WORDCNT_EN
  logic words_inc;
  assign words_inc = step_en & (state_q == LOCKED);

  sat_counter #(
    .W(CNT_W)
  ) u_words_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(words_inc),
    .clr_i(clr_i),
    .cnt_o(words_cnt_o)
  );
`else
  assign words_cnt_o = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a 16-bit and a 4-bit counter build share one stimulus stream.
module tb_lfsr_checker;

  localparam int unsigned LockT = 4;
  localparam int unsigned LossT = 3;
  localparam int MH = 0;
  localparam int MV = 1;
  localparam int ML = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_i = '0;
  logic        data_v = 1'b0;
  logic        seed_v = 1'b0;
  logic        clr_i = 1'b0;

  logic        locked_a, err_a, locked_b, err_b;
  logic [15:0] ecnt_a, wcnt_a;
  logic [3:0]  ecnt_b, wcnt_b;

  lfsr_checker #(
    .LOCK_THRESH(LockT),
    .LOSS_THRESH(LossT),
    .CNT_W      (16)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .data_v     (data_v),
    .seed_v     (seed_v),
    .clr_i      (clr_i),
    .locked_o   (locked_a),
    .err_o      (err_a),
    .err_cnt_o  (ecnt_a),
    .words_cnt_o(wcnt_a)
  );

  lfsr_checker #(
    .LOCK_THRESH(LockT),
    .LOSS_THRESH(LossT),
    .CNT_W      (4)
  ) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .data_v     (data_v),
    .seed_v     (seed_v),
    .clr_i      (clr_i),
    .locked_o   (locked_b),
    .err_o      (err_b),
    .err_cnt_o  (ecnt_b),
    .words_cnt_o(wcnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        locked;
    logic        err;
    int unsigned ec16;
    int unsigned ec4;
    int unsigned wc16;
    int unsigned wc4;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state (unbounded counts; saturation applied when publishing).
  int          m_mode;
  logic [31:0] m_pred;
  int          m_run, m_miss;
  logic        m_locked, m_err;
  int unsigned m_ec, m_wc;
  logic [31:0] g;

  function automatic logic [31:0] ref_step(input logic [31:0] x);
    logic nb;
    nb = x[31] ^ x[30] ^ x[29] ^ x[27] ^ x[25] ^ x[0];
    return {nb, x[31:1]};
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned max);
    return (v > max) ? max : v;
  endfunction

  task automatic model(input logic rn, input logic dv, input logic [31:0] d, input logic sv,
                       input logic clr);
    exp_t e;
    logic mis;
    logic cnt_word;
    mis = 1'b0;
    cnt_word = 1'b0;
    if (!rn) begin
      m_mode = MH; m_pred = '0; m_run = 0; m_miss = 0;
      m_locked = 1'b0; m_err = 1'b0; m_ec = 0; m_wc = 0;
    end else begin
      m_err = 1'b0;
      if (sv) begin
        m_mode = MH; m_run = 0; m_miss = 0; m_locked = 1'b0;
      end else if (dv) begin
        if (m_mode == MH) begin
          if (d != 0) begin m_pred = ref_step(d); m_run = 0; m_mode = MV; end
        end else if (m_mode == MV) begin
          if (d == m_pred) begin
            m_run++;
            if (m_run == LockT) begin m_mode = ML; m_locked = 1'b1; end
          end else m_run = 0;
          m_pred = ref_step(d);
        end else begin
          cnt_word = 1'b1;
          if (d == m_pred) m_miss = 0;
          else begin
            mis = 1'b1; m_err = 1'b1; m_miss++;
            if (m_miss == LossT) begin m_mode = MH; m_locked = 1'b0; m_miss = 0; end
          end
          m_pred = ref_step(m_pred);
        end
      end
      if (clr) begin m_ec = 0; m_wc = 0; end
      else begin
        if (mis) m_ec++;
        if (cnt_word) m_wc++;
      end
    end
    e.locked = m_locked;
    e.err    = m_err;
    e.ec16   = sat(m_ec, 65535);
    e.ec4    = sat(m_ec, 15);
`ifdef LFSR_CHK_WORDCNT_EN
    e.wc16   = sat(m_wc, 65535);
    e.wc4    = sat(m_wc, 15);
`else
    e.wc16   = 0;
    e.wc4    = 0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic rn, input logic dv, input logic [31:0] d, input logic sv,
                     input logic clr);
    rst = rn; data_v = dv; data_i = d; seed_v = sv; clr_i = clr;
    model(rn, dv, d, sv, clr);
    @(posedge clk);
    #2;
  endtask

  task automatic gap();
    if ($urandom_range(0, 3) == 0) cyc(1'b1, 1'b0, $urandom, 1'b0, 1'b0);
  endtask

  task automatic send_good();
    gap();
    cyc(1'b1, 1'b1, g, 1'b0, 1'b0);
    g = ref_step(g);
  endtask

  task automatic send_bad(input logic clr);
    logic [31:0] m;
    m = 32'h1 << $urandom_range(0, 31);
    cyc(1'b1, 1'b1, g ^ m, 1'b0, clr);
    g = ref_step(g);
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are registered, so each pushed expectation is due just after the next edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("locked16", 32'(locked_a), 32'(e.locked));
        chk("err16",    32'(err_a),    32'(e.err));
        chk("errcnt16", 32'(ecnt_a),   e.ec16);
        chk("wordcnt16", 32'(wcnt_a),  e.wc16);
        chk("locked4",  32'(locked_b), 32'(e.locked));
        chk("err4",     32'(err_b),    32'(e.err));
        chk("errcnt4",  32'(ecnt_b),   e.ec4);
        chk("wordcnt4", 32'(wcnt_b),   e.wc4);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] start [5];
    int r;
    start[0] = 32'h00000001; start[1] = 32'h80000000; start[2] = 32'hC0000000;
    start[3] = 32'h60000000; start[4] = 32'h30000000;

    repeat (2) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);

    // Acquisition from the documented start sequence, then continue the true stream.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, start[i], 1'b0, 1'b0);
    g = ref_step(start[4]);
    repeat (10) send_good();

    // Single corrupted word, then resume.
    send_bad(1'b0);
    repeat (8) send_good();

    // Three consecutive corrupted words drop lock; relock afterwards.
    repeat (3) send_bad(1'b0);
    repeat (7) send_good();

    // Zero words in HUNT are ignored.
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    repeat (10) cyc(1'b1, 1'b1, '0, 1'b0, 1'b0);
    repeat (7) send_good();

    // Reseed together with a word, then a new stream.
    cyc(1'b1, 1'b1, g, 1'b1, 1'b0);
    g = 32'h12345678;
    repeat (8) send_good();

    // Drive the 4-bit build into saturation with relocks between bursts.
    for (int b = 0; b < 7; b++) begin
      repeat (3) send_bad(1'b0);
      repeat (6) send_good();
    end
    send_bad(1'b1);
    repeat (4) send_good();

    // Reset in the middle of the stream.
    cyc(1'b0, 1'b1, g, 1'b0, 1'b0);
    g = ref_step(g);
    repeat (7) send_good();

    // Random soak.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        cyc(1'b1, $urandom_range(0, 1) == 1, $urandom, 1'b1, 1'b0);
        g = $urandom | 32'h1;
      end else if (r < 4) begin
        cyc(1'b1, 1'b0, $urandom, 1'b0, 1'b1);
      end else if (r < 12) begin
        send_bad(r == 11);
      end else begin
        send_good();
      end
    end

    repeat (3) cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
